pipe_reg_with_flow_control: RTL and testbench
=============================================

Name: pipe_reg_with_flow_control

Overview:
- Pipeline register stage with full valid/ready flow control: a two-entry skid buffer.
- Counterpart of the valid-only pipeline register; used where the downstream stage can stall and backpressure must propagate upstream.
- Keeps full throughput (one transfer per cycle) while `up_rdy` is driven only from flops, so there is no combinational path from `down_rdy` to `up_rdy`.
- Sits between any two pipeline stages of the pow_5 datapath family.

Parameters:
- `w`, default 8: data width in bits; must be ≥ 1.

Ports:
- `clk`, in, 1: clock; all state changes on the rising edge.
- `rst`, in, 1: reset, asynchronous, active-low; asserted when 0.
- `up_vld`, in, 1: upstream data valid.
- `up_rdy`, out, 1: block can accept data; a transfer occurs when `up_vld && up_rdy`.
- `up_data`, in, `w`: upstream data.
- `down_vld`, out, 1: output data valid.
- `down_rdy`, in, 1: downstream accepts; a transfer occurs when `down_vld && down_rdy`.
- `down_data`, out, `w`: output data.

Behaviour:
- Storage:
  - main register (`main_data`, `main_vld`) drives `down_data` / `down_vld` directly.
  - skid register (`skid_data`, `skid_vld`).
  - `up_rdy` is a flop equal to `!skid_vld`.
- States: EMPTY (`main_vld=0`, `skid_vld=0`), BUSY (`main_vld=1`, `skid_vld=0`), FULL (`main_vld=1`, `skid_vld=1`). The state `main_vld=0`, `skid_vld=1` is illegal and unreachable.
- Reset (`rst`=0, asynchronous): `main_vld=0`, `skid_vld=0`, `up_rdy=1`, `down_vld=0`. Data registers have no reset; `down_data` is don't-care while `down_vld=0`.
- Reset mid-operation drops all held items with no output pulse. The first cycle after release behaves as EMPTY.
- Transitions (`in` = `up_vld && up_rdy`, `out` = `down_vld && down_rdy`):
  - EMPTY, in → BUSY; main loads `up_data`. Latency is exactly 1 cycle: data accepted at edge N is visible on `down_data` after edge N.
  - BUSY, in && out → BUSY; main loads `up_data` (streaming, one item per cycle).
  - BUSY, in && !out → FULL; skid loads `up_data`; main holds; `up_rdy` goes 0 after the edge.
  - BUSY, !in && out → EMPTY.
  - BUSY, !in && !out → BUSY; main holds.
  - FULL, out → BUSY; main loads `skid_data`; `up_rdy` goes 1. The `up_vld` input is ignored, since `up_rdy`=0.
  - FULL, !out → FULL; everything holds.
- Ordering: strict FIFO. No item is lost or duplicated.
- Output stability: `down_data` and `down_vld` are stable while `down_vld && !down_rdy`.
- `up_data` is sampled only on an `in` transfer. Data-register enables are gated by the load conditions, to save dynamic power.
- `down_rdy` may toggle freely, including when `down_vld`=0; it has no effect in EMPTY.
- Max occupancy is 2. After `down_rdy` falls, at most one further item is accepted.

Optional Feature:
- Macro: `PIPE_REG_WITH_FLOW_CONTROL_STALL_CNT_EN`.
- Defined:
  - Adds output port `stall_cnt`, out, 16: counts cycles with `down_vld && !down_rdy`.
  - Saturates at 16'hFFFF with no wrap.
  - Reset value 0 via `rst`.
  - Has no effect on the datapath or handshake timing.
- Undefined: port `stall_cnt` and its counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset release with `up_vld`=0 → `down_vld`=0 and `up_rdy`=1 every cycle; `stall_cnt`=0 (if enabled).
- Streaming: `down_rdy`=1, send 8'h01..8'h10 on consecutive cycles → `down_data` = 8'h01..8'h10 on consecutive cycles, each 1 cycle after acceptance; `up_rdy` stays 1.
- Backpressure: send 8'hA1, 8'hA2, 8'hA3 back-to-back with `down_rdy`=0 from the first cycle:
  - `up_rdy` drops after 8'hA2 is accepted; 8'hA3 is held upstream.
  - Raise `down_rdy` after 5 cycles → output order A1, A2, A3 with no loss.
  - `stall_cnt`=5 (if enabled).
- Random `up_vld`/`down_rdy` over 10,000 cycles against a scoreboard:
  - all items delivered in order;
  - `down_data` stable while stalled;
  - `up_rdy` never 0 when occupancy < 2.
- Asynchronous reset asserted mid-cycle in FULL → `down_vld`=0 and `up_rdy`=1 immediately, without waiting for a clock edge; no held item appears after release.
- Stall counter saturation (macro defined): hold `down_vld`=1, `down_rdy`=0 for 70,000 cycles → `stall_cnt`=16'hFFFF, with no wrap to 0.

Source files
------------

// File: rtl/pipe_reg_with_flow_control_if.sv
// Valid/ready handshake bundle for pipe_reg_with_flow_control: upstream and downstream sides.
// The slave modport is the register stage; the master modport is its environment.
interface pipe_reg_with_flow_control_if #(
    parameter int w = 8
);
    logic         up_vld;
    logic         up_rdy;
    logic [w-1:0] up_data;
    logic         down_vld;
    logic         down_rdy;
    logic [w-1:0] down_data;

    modport slave (
        input  up_vld,
        input  up_data,
        input  down_rdy,
        output up_rdy,
        output down_vld,
        output down_data
    );

    modport master (
        output up_vld,
        output up_data,
        output down_rdy,
        input  up_rdy,
        input  down_vld,
        input  down_data
    );
endinterface

// File: rtl/pipe_reg_with_flow_control.sv
// Two-entry skid-buffer pipeline register with registered up_rdy (no down_rdy -> up_rdy path).
// Optional stall counter output enabled by macro PIPE_REG_WITH_FLOW_CONTROL_STALL_CNT_EN.
module pipe_reg_with_flow_control #(
    parameter int w = 8
) (
    input  logic clk,
    input  logic rst,
`ifdef PIPE_REG_WITH_FLOW_CONTROL_STALL_CNT_EN
    output logic [15:0] stall_cnt,
`endif
    pipe_reg_with_flow_control_if.slave bus
);
    // State encoding is {main_vld, skid_vld}; 2'b01 can never be entered.
    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] BUSY  = 2'b10;
    localparam logic [1:0] FULL  = 2'b11;

    logic [1:0]   state;
    logic [1:0]   state_nxt;
    logic         up_rdy_q;
    logic         main_vld;
    logic         skid_vld;
    logic [w-1:0] main_data;
    logic [w-1:0] skid_data;
    logic         in_xfer;
    logic         out_xfer;
    logic         main_load_up;
    logic         main_load_skid;
    logic         skid_load;

    assign main_vld = state[1];
    assign skid_vld = state[0];
    assign in_xfer  = bus.up_vld && up_rdy_q;
    assign out_xfer = main_vld && bus.down_rdy;

    always_comb begin
        state_nxt      = state;
        main_load_up   = 1'b0;
        main_load_skid = 1'b0;
        skid_load      = 1'b0;
        case (state)
            EMPTY: begin
                if (in_xfer) begin
                    main_load_up = 1'b1;
                    state_nxt    = BUSY;
                end
            end
            BUSY: begin
                if (in_xfer && out_xfer) begin
                    main_load_up = 1'b1;
                end else if (in_xfer) begin
                    skid_load = 1'b1;
                    state_nxt = FULL;
                end else if (out_xfer) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (out_xfer) begin
                    main_load_skid = 1'b1;
                    state_nxt      = BUSY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // Control stage: occupancy and registered ready, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= EMPTY;
            up_rdy_q <= 1'b1;
        end else begin
            state    <= state_nxt;
            up_rdy_q <= !state_nxt[0];
        end
    end

    // Data stage: no reset, registers only clock in on their load condition.
    always_ff @(posedge clk) begin
        if (main_load_up) begin
            main_data <= bus.up_data;
        end else if (main_load_skid) begin
            main_data <= skid_data;
        end
        if (skid_load) begin
            skid_data <= bus.up_data;
        end
    end

    assign bus.up_rdy    = up_rdy_q;
    assign bus.down_vld  = main_vld;
    assign bus.down_data = main_data;

`ifdef PIPE_REG_WITH_FLOW_CONTROL_STALL_CNT_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Stall counter stage: observes the handshake only, never feeds back into it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= 16'd0;
        end else if (main_vld && !bus.down_rdy) begin
            stall_cnt <= sat_inc(stall_cnt);
        end
    end
`endif
endmodule

// File: tb/tb_pipe_reg_with_flow_control.sv
// Directed vector table plus hand-written reset/random/saturation sequences for the skid buffer.
module tb_pipe_reg_with_flow_control;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_reg_with_flow_control_if #(.w(8)) bus();
`ifdef PIPE_REG_WITH_FLOW_CONTROL_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    pipe_reg_with_flow_control #(.w(8)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef PIPE_REG_WITH_FLOW_CONTROL_STALL_CNT_EN
        .stall_cnt (stall_cnt),
`endif
        .bus       (bus)
    );

    typedef struct {
        logic       up_vld;
        logic [7:0] up_data;
        logic       down_rdy;
        logic       exp_up_rdy;
        logic       exp_down_vld;
        logic [7:0] exp_data;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] sb[$];
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic add(input logic uv, input logic [7:0] ud, input logic dr,
                       input logic eur, input logic edv, input logic [7:0] ed);
        vec_t v;
        v.up_vld = uv; v.up_data = ud; v.down_rdy = dr;
        v.exp_up_rdy = eur; v.exp_down_vld = edv; v.exp_data = ed;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic uv, input logic [7:0] ud, input logic dr);
        bus.up_vld   = uv;
        bus.up_data  = ud;
        bus.down_rdy = dr;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic       prev_stall;
        logic [7:0] prev_data;
        logic       in_x, out_x;

        rst = 1'b1;
        drive(1'b0, 8'h00, 1'b0);
        #1 rst = 1'b0;
        #1;
        check("rst_down_vld", {31'd0, bus.down_vld}, 32'd0);
        check("rst_up_rdy", {31'd0, bus.up_rdy}, 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // idle after reset, down_rdy toggling has no effect
        add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
        add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00);
        add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
        // streaming 01..10
        for (int i = 1; i <= 16; i++) begin
            logic [7:0] d;
            d = 8'(i);
            add(1'b1, d, 1'b1, 1'b1, 1'b1, d);
        end
        add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00);
        // backpressure A1..A3, down_rdy low for six cycles
        add(1'b1, 8'hA1, 1'b0, 1'b1, 1'b1, 8'hA1);
        add(1'b1, 8'hA2, 1'b0, 1'b0, 1'b1, 8'hA1);
        for (int i = 0; i < 4; i++) add(1'b1, 8'hA3, 1'b0, 1'b0, 1'b1, 8'hA1);
        add(1'b1, 8'hA3, 1'b1, 1'b1, 1'b1, 8'hA2);
        add(1'b1, 8'hA3, 1'b1, 1'b1, 1'b1, 8'hA3);
        add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00);
        // BUSY hold then drain
        add(1'b1, 8'hB1, 1'b0, 1'b1, 1'b1, 8'hB1);
        add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hB1);
        add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00);

        foreach (tbl[i]) begin
            drive(tbl[i].up_vld, tbl[i].up_data, tbl[i].down_rdy);
            @(negedge clk);
            check($sformatf("vec%0d_up_rdy", i), {31'd0, bus.up_rdy}, {31'd0, tbl[i].exp_up_rdy});
            check($sformatf("vec%0d_down_vld", i), {31'd0, bus.down_vld}, {31'd0, tbl[i].exp_down_vld});
            if (tbl[i].exp_down_vld)
                check($sformatf("vec%0d_down_data", i), {24'd0, bus.down_data}, {24'd0, tbl[i].exp_data});
        end
`ifdef PIPE_REG_WITH_FLOW_CONTROL_STALL_CNT_EN
        check("stall_cnt_directed", {16'd0, stall_cnt}, 32'd6);
`endif

        // random traffic against a FIFO scoreboard
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        for (int c = 0; c < 10000; c++) begin
            check("rnd_down_vld", {31'd0, bus.down_vld}, {31'd0, sb.size() > 0});
            check("rnd_up_rdy", {31'd0, bus.up_rdy}, {31'd0, sb.size() < 2});
            if (prev_stall) check("rnd_stable", {24'd0, bus.down_data}, {24'd0, prev_data});
            drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) != 0 ? (c % 200 < 100) : ($urandom_range(0, 1))));
            in_x  = bus.up_vld && bus.up_rdy;
            out_x = bus.down_vld && bus.down_rdy;
            if (out_x) begin
                if (sb.size() == 0) check("rnd_underflow", 32'd1, 32'd0);
                else check("rnd_order", {24'd0, bus.down_data}, {24'd0, sb.pop_front()});
            end
            if (in_x) sb.push_back(bus.up_data);
            prev_stall = bus.down_vld && !bus.down_rdy;
            prev_data  = bus.down_data;
            @(negedge clk);
        end
        drive(1'b0, 8'h00, 1'b1);
        repeat (3) @(negedge clk);
        check("drain_down_vld", {31'd0, bus.down_vld}, 32'd0);

        // async reset while FULL
        drive(1'b1, 8'hC1, 1'b0);
        @(negedge clk);
        drive(1'b1, 8'hC2, 1'b0);
        @(negedge clk);
        check("full_up_rdy", {31'd0, bus.up_rdy}, 32'd0);
        drive(1'b0, 8'h00, 1'b0);
        #2 rst = 1'b0;
        #1;
        check("arst_down_vld", {31'd0, bus.down_vld}, 32'd0);
        check("arst_up_rdy", {31'd0, bus.up_rdy}, 32'd1);
`ifdef PIPE_REG_WITH_FLOW_CONTROL_STALL_CNT_EN
        check("arst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_down_vld", {31'd0, bus.down_vld}, 32'd0);
            check("post_rst_up_rdy", {31'd0, bus.up_rdy}, 32'd1);
        end

`ifdef PIPE_REG_WITH_FLOW_CONTROL_STALL_CNT_EN
        drive(1'b1, 8'hD1, 1'b0);
        @(negedge clk);
        drive(1'b0, 8'h00, 1'b0);
        repeat (70000) @(negedge clk);
        check("sat_stall_cnt", {16'd0, stall_cnt}, 32'h0000FFFF);
        @(negedge clk);
        check("sat_no_wrap", {16'd0, stall_cnt}, 32'h0000FFFF);
        check("sat_down_data", {24'd0, bus.down_data}, 32'h000000D1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
